// File: rtl/cpu_clk_ctrl_if.sv
// Request/status bundle between the CPU clock sequencer and its controller
// (debug unit or board logic). The controller drives the requests and the
// sequencer drives the clock outputs and status.
interface cpu_clk_ctrl_if #(
   parameter int BURST_W = 16
);
   logic               run_req;
   logic               halt_req;
   logic               step_req;
   logic               burst_req;
   logic [BURST_W-1:0] burst_len;
   logic               cpu_clk;
   logic               cpu_ce;
   logic               halted;
   logic               done;
   logic [31:0]        cycle_count;

   modport master (
      output run_req, halt_req, step_req, burst_req, burst_len,
      input  cpu_clk, cpu_ce, halted, done, cycle_count
   );

   modport slave (
      input  run_req, halt_req, step_req, burst_req, burst_len,
      output cpu_clk, cpu_ce, halted, done, cycle_count
   );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock sequencer for the 6502 core. Divides the system clock by DIV to
// produce a square-wave cpu_clk and a one-clock cpu_ce strobe at the end of
// each CPU cycle. A run/halt/step/burst state machine gates cycle generation;
// every state change that stops the CPU lands on a CPU-cycle boundary.
module cpu_clk_ctrl #(
   parameter int SYS_CLK = 50000000,
   parameter int CLK_OUT = 1000000,
   parameter int DIV     = SYS_CLK / CLK_OUT,
   parameter int BURST_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   cpu_clk_ctrl_if.slave bus
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   // Last phase of a CPU cycle; the edge leaving it is the wrap edge.
   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
   // Phase whose exit raises cpu_clk; odd DIV gives the longer high half.
   localparam logic [PW-1:0] PH_RISE = PW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      ST_HALT  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STOP  = 3'd2,
      ST_STEP  = 3'd3,
      ST_BURST = 3'd4
   } state_t;

   state_t             state_r;
   logic [PW-1:0]      phase_r;
   logic               cpu_clk_r;
   logic               cpu_ce_r;
   logic               halted_r;
   logic               done_r;
   logic [31:0]        count_r;
   logic [BURST_W-1:0] remaining_r;
   logic               wrap_s;

   // The phase counter only moves outside HALT, so a wrap is impossible there.
   assign wrap_s = (state_r != ST_HALT) && (phase_r == PH_LAST);

   // Divider, strobes and run/halt/step/burst sequencing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_HALT;
         phase_r     <= '0;
         cpu_clk_r   <= 1'b0;
         cpu_ce_r    <= 1'b0;
         halted_r    <= 1'b1;
         done_r      <= 1'b0;
         count_r     <= 32'd0;
         remaining_r <= '0;
      end else begin
         cpu_ce_r <= 1'b0;
         done_r   <= 1'b0;

         if (state_r == ST_HALT) begin
            phase_r   <= '0;
            cpu_clk_r <= 1'b0;
         end else if (wrap_s) begin
            phase_r   <= '0;
            cpu_clk_r <= 1'b0;
            cpu_ce_r  <= 1'b1;
            count_r   <= count_r + 32'd1;
         end else begin
            phase_r <= phase_r + PW'(1);
            if (phase_r == PH_RISE) begin
               cpu_clk_r <= 1'b1;
            end else begin
               cpu_clk_r <= cpu_clk_r;
            end
         end

         case (state_r)
            ST_HALT: begin
               if (bus.halt_req) begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end else if (bus.step_req) begin
                  state_r  <= ST_STEP;
                  halted_r <= 1'b0;
               end else if (bus.burst_req) begin
                  if (bus.burst_len != '0) begin
                     remaining_r <= bus.burst_len;
                     state_r     <= ST_BURST;
                     halted_r    <= 1'b0;
                  end else begin
                     // Zero-length burst completes immediately without a cycle.
                     done_r   <= 1'b1;
                     state_r  <= ST_HALT;
                     halted_r <= 1'b1;
                  end
               end else if (bus.run_req) begin
                  state_r  <= ST_RUN;
                  halted_r <= 1'b0;
               end else begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.halt_req || !bus.run_req) begin
                  state_r <= ST_STOP;
               end else begin
                  state_r <= ST_RUN;
               end
               halted_r <= 1'b0;
            end
            ST_STOP: begin
               if (wrap_s) begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end else begin
                  state_r  <= ST_STOP;
                  halted_r <= 1'b0;
               end
            end
            ST_STEP: begin
               if (wrap_s) begin
                  done_r   <= 1'b1;
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end else begin
                  state_r  <= ST_STEP;
                  halted_r <= 1'b0;
               end
            end
            ST_BURST: begin
               if (wrap_s && (remaining_r == BURST_W'(1))) begin
                  remaining_r <= '0;
                  done_r      <= 1'b1;
                  state_r     <= ST_HALT;
                  halted_r    <= 1'b1;
               end else if (wrap_s) begin
                  remaining_r <= remaining_r - BURST_W'(1);
                  state_r     <= bus.halt_req ? ST_STOP : ST_BURST;
                  halted_r    <= 1'b0;
               end else if (bus.halt_req) begin
                  // Abandon the burst; the current cycle still completes.
                  state_r  <= ST_STOP;
                  halted_r <= 1'b0;
               end else begin
                  state_r  <= ST_BURST;
                  halted_r <= 1'b0;
               end
            end
            default: begin
               state_r  <= ST_HALT;
               halted_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cpu_clk     = cpu_clk_r;
   assign bus.cpu_ce      = cpu_ce_r;
   assign bus.halted      = halted_r;
   assign bus.done        = done_r;
   assign bus.cycle_count = count_r;

endmodule
